// File: rtl/bf_io_spi_scheduler.sv
// Purpose: shares one SPI master between the interpreter's output port (cs_n[0]) and input polling (cs_n[1]), round-robin.
// Latency: output byte on the wire from the cycle after accept; input byte valid (4*WORD_SIZE+3)*CLK_DIV+1 cycles after grant.
// Backpressure: out_ready only in IDLE when output is granted; a captured input byte is held in DELIVER until in_ready.
//
// Ports: clk/rst (synchronous, active-high); out_data/out_valid/out_ready from the interpreter;
// in_data/in_valid/in_ready to the interpreter; spi_sck/spi_mosi/spi_miso/spi_cs_n to the board; busy = not IDLE.
// Optional feature macro: BF_POLL_BACKOFF_EN -- after an empty poll, input is not granted for POLL_GAP cycles.
module bf_io_spi_scheduler #(
    parameter int WORD_SIZE = 8,
    parameter int CLK_DIV   = 4,
    parameter int POLL_GAP  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] out_data,
    input  logic                 out_valid,
    output logic                 out_ready,
    output logic [WORD_SIZE-1:0] in_data,
    output logic                 in_valid,
    input  logic                 in_ready,
    output logic                 spi_sck,
    output logic                 spi_mosi,
    input  logic                 spi_miso,
    output logic [1:0]           spi_cs_n,
    output logic                 busy
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(WORD_SIZE + 1);
    localparam int BO_W  = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_LO,
        SHIFT_HI,
        HOLD,
        GAP,
        DELIVER
    } state_t;

    state_t state, state_nxt;

    logic [DIV_W-1:0]     div_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [BO_W-1:0]      backoff;
    logic [WORD_SIZE-1:0] shreg;
    logic                 miso_q;
    logic                 sel_in;         // current transaction targets the input device
    logic                 byte_idx;       // 0 = first byte (status for input), 1 = second byte
    logic                 have_data;      // an input byte was captured and awaits delivery
    logic                 last_grant_in;

    logic                 div_end;
    logic                 bit_last;
    logic                 miso_bit;
    logic [WORD_SIZE-1:0] shreg_nxt;
    logic                 in_cand;
    logic                 grant_out;
    logic                 grant_in;
    logic [1:0]           cs_active;

    assign div_end  = (div_cnt == DIV_LAST);
    assign bit_last = (bit_cnt == BIT_LAST);

    // MISO is sampled in the first SHIFT_HI cycle; with CLK_DIV=1 that cycle is also the shift cycle.
    assign miso_bit  = (div_cnt == '0) ? spi_miso : miso_q;
    assign shreg_nxt = {shreg[WORD_SIZE-2:0], miso_bit};

    // Round-robin: on a tie, the side not granted last time wins.
    assign in_cand   = in_ready && (backoff == '0);
    assign grant_out = out_valid && (!in_cand || last_grant_in);
    assign grant_in  = in_cand && !grant_out;

    assign cs_active = sel_in ? 2'b01 : 2'b10;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        spi_sck   = 1'b0;
        spi_mosi  = 1'b0;
        spi_cs_n  = 2'b11;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant_out) begin
                    out_ready = !rst;
                    state_nxt = SETUP;
                end else if (grant_in) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                spi_cs_n = cs_active;
                spi_mosi = !sel_in && shreg[WORD_SIZE-1];
                if (div_end) state_nxt = SHIFT_LO;
            end
            SHIFT_LO: begin
                spi_cs_n = cs_active;
                spi_mosi = !sel_in && shreg[WORD_SIZE-1];
                if (div_end) state_nxt = SHIFT_HI;
            end
            SHIFT_HI: begin
                spi_cs_n = cs_active;
                spi_sck  = 1'b1;
                spi_mosi = !sel_in && shreg[WORD_SIZE-1];
                if (div_end) begin
                    if (!bit_last) begin
                        state_nxt = SHIFT_LO;
                    end else if (sel_in && !byte_idx && (shreg_nxt != '0)) begin
                        // non-zero status: continue straight into the data byte, CS stays low
                        state_nxt = SHIFT_LO;
                    end else begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                spi_cs_n = cs_active;
                if (div_end) state_nxt = GAP;
            end
            GAP: begin
                if (div_end) state_nxt = have_data ? DELIVER : IDLE;
            end
            DELIVER: begin
                in_valid = 1'b1;
                if (in_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt       <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            miso_q        <= 1'b0;
            sel_in        <= 1'b0;
            byte_idx      <= 1'b0;
            have_data     <= 1'b0;
            last_grant_in <= 1'b1;
            in_data       <= '0;
            backoff       <= '0;
        end else begin
            if (state inside {SETUP, SHIFT_LO, SHIFT_HI, HOLD, GAP}) begin
                div_cnt <= div_end ? '0 : div_cnt + 1'b1;
            end else begin
                div_cnt <= '0;
            end

            case (state)
                IDLE: begin
                    if (grant_out) begin
                        shreg         <= out_data;
                        sel_in        <= 1'b0;
                        last_grant_in <= 1'b0;
                        byte_idx      <= 1'b0;
                        bit_cnt       <= '0;
                        have_data     <= 1'b0;
                    end else if (grant_in) begin
                        shreg         <= '0;
                        sel_in        <= 1'b1;
                        last_grant_in <= 1'b1;
                        byte_idx      <= 1'b0;
                        bit_cnt       <= '0;
                        have_data     <= 1'b0;
                    end
                end
                SHIFT_HI: begin
                    if (div_cnt == '0) miso_q <= spi_miso;
                    if (div_end) begin
                        shreg <= shreg_nxt;
                        if (bit_last) begin
                            bit_cnt  <= '0;
                            byte_idx <= 1'b1;
                            if (sel_in && byte_idx) begin
                                in_data   <= shreg_nxt;
                                have_data <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                DELIVER: begin
                    if (in_ready) have_data <= 1'b0;
                end
                default: ;
            endcase

`ifdef BF_POLL_BACKOFF_EN
            // Armed as the empty poll leaves GAP; the first IDLE cycle sees the full POLL_GAP.
            if (state == GAP && div_end && sel_in && !have_data) begin
                backoff <= BO_W'(POLL_GAP);
            end else if (backoff != '0) begin
                backoff <= backoff - 1'b1;
            end
`else
            backoff <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_bf_io_spi_scheduler.sv
// Bench for bf_io_spi_scheduler: SPI slave model for the input device, bus monitor, directed and random transactions.
// Expected values come from transaction-level rules: CS window lengths, byte order, grant order and delivery latency.
module tb_bf_io_spi_scheduler;
    localparam int W  = 8;
    localparam int D  = 2;
    localparam int PG = 10;
    localparam int LEN_SHORT      = (2 * W + 2) * D;
    localparam int LEN_LONG       = (4 * W + 2) * D;
    localparam int VALID_AFTER_CS = (4 * W + 3) * D;
`ifdef BF_POLL_BACKOFF_EN
    localparam int POLL_HI = D + PG + 1;
`else
    localparam int POLL_HI = D + 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] out_data = '0;
    logic         out_valid = 1'b0;
    logic         out_ready;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready = 1'b0;
    logic         spi_sck;
    logic         spi_mosi;
    logic         spi_miso = 1'b0;
    logic [1:0]   spi_cs_n;
    logic         busy;

    int checks = 0;
    int errors = 0;

    bf_io_spi_scheduler #(.WORD_SIZE(W), .CLK_DIV(D), .POLL_GAP(PG)) dut (
        .clk(clk), .rst(rst),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .spi_cs_n(spi_cs_n), .busy(busy)
    );

    always #5 clk = ~clk;

    // Monitor / slave state
    logic [15:0] dev_q[$];
    int          len0_q[$];
    int          len1_q[$];
    int          bits_q[$];
    logic [7:0]  byte_q[$];
    logic        mor_q[$];
    logic [7:0]  acc_q[$];
    logic [7:0]  deliv_q[$];
    int          grant_q[$];
    int          gap_q[$];
    int          viol = 0;
    int          run = 0;
    int          hi_run = 0;
    int          nbits = 0;
    logic [7:0]  macc = '0;
    logic        mor = 1'b0;
    logic        prev_sck = 1'b0;
    logic [1:0]  prev_cs = 2'b11;
    logic [15:0] sreg = '0;

    always @(negedge clk) begin
        // input device: status then data, MSB first, next bit presented after each SCK fall
        if (spi_cs_n[1] == 1'b0 && prev_cs[1] == 1'b1) begin
            sreg = (dev_q.size() > 0) ? dev_q.pop_front() : 16'h0000;
            spi_miso = sreg[15];
        end else if (spi_cs_n[1] == 1'b0 && prev_sck && !spi_sck) begin
            sreg = {sreg[14:0], 1'b0};
            spi_miso = sreg[15];
        end else if (spi_cs_n[1] == 1'b1) begin
            spi_miso = 1'b0;
        end

        if (spi_cs_n == 2'b00) viol++;
        if (spi_cs_n != 2'b11 && prev_cs == 2'b11) begin
            grant_q.push_back((spi_cs_n == 2'b10) ? 0 : 1);
            gap_q.push_back(hi_run);
            run = 0; nbits = 0; macc = '0; mor = 1'b0;
        end
        if (spi_cs_n != 2'b11) begin
            run++;
            if (spi_sck && !prev_sck) begin
                macc = {macc[6:0], spi_mosi};
                nbits++;
                mor = mor | spi_mosi;
            end
        end
        if (spi_cs_n == 2'b11 && prev_cs != 2'b11) begin
            if (prev_cs == 2'b10) begin
                len0_q.push_back(run); bits_q.push_back(nbits); byte_q.push_back(macc);
            end else begin
                len1_q.push_back(run); mor_q.push_back(mor);
            end
            hi_run = 0;
        end
        if (spi_cs_n == 2'b11) hi_run++;

        if (out_valid && out_ready) acc_q.push_back(out_data);
        if (in_valid && in_ready) deliv_q.push_back(in_data);
        prev_sck = spi_sck;
        prev_cs  = spi_cs_n;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy !== 1'b0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("idle_reached", busy, 1'b0);
    endtask

    task automatic clear_mon();
        len0_q.delete(); len1_q.delete(); bits_q.delete(); byte_q.delete(); mor_q.delete();
        acc_q.delete(); deliv_q.delete(); grant_q.delete(); gap_q.delete();
    endtask

    task automatic do_output(input logic [7:0] b);
        int k = 0;
        acc_q.delete();
        @(posedge clk); #1;
        out_data = b; out_valid = 1'b1;
        @(negedge clk);
        while (out_ready !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("out_ready", out_ready, 1'b1);
        @(posedge clk); #1;
        out_valid = 1'b0; out_data = 8'($urandom);
        @(negedge clk);
        chk("out_cs_start", spi_cs_n, 2'b10);
        chk("out_ready_pulse", out_ready, 1'b0);
        wait_idle();
        chk("out_cs_len", (len0_q.size() > 0) ? len0_q.pop_front() : -1, LEN_SHORT);
        chk("out_bits", (bits_q.size() > 0) ? bits_q.pop_front() : -1, W);
        chk("out_mosi_byte", (byte_q.size() > 0) ? {24'h0, byte_q.pop_front()} : 32'h1ff, {24'h0, b});
        chk("out_accepts", acc_q.size(), 1);
        chk("out_no_in_cs", len1_q.size(), 0);
    endtask

    task automatic do_input(input logic [7:0] status, input logic [7:0] data, input int hold, input bit check_grant);
        int k = 0;
        dev_q.push_back({status, data});
        deliv_q.delete();
        @(posedge clk); #1;
        in_ready = 1'b1;
        @(negedge clk);
        while (spi_cs_n[1] !== 1'b0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("in_cs_start", spi_cs_n, 2'b01);
        if (check_grant) chk("in_grant_latency", k, 1);
        if (status == 8'h00) begin
            in_ready = 1'b0;
            wait_idle();
            chk("poll_cs_len", (len1_q.size() > 0) ? len1_q.pop_front() : -1, LEN_SHORT);
            chk("poll_mosi_zero", (mor_q.size() > 0) ? mor_q.pop_front() : 1'bx, 1'b0);
            chk("poll_no_delivery", deliv_q.size(), 0);
            chk("poll_in_valid", in_valid, 1'b0);
        end else begin
            in_ready = (hold == 0);
            k = 0;
            while (in_valid !== 1'b1 && k < 400) begin
                @(negedge clk);
                k++;
            end
            chk("in_valid_latency", k, VALID_AFTER_CS);
            chk("in_data", in_data, data);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("held_delivery", {in_valid, spi_cs_n, spi_sck, busy, in_data},
                    {1'b1, 2'b11, 1'b0, 1'b1, data});
            end
            if (hold != 0) begin
                @(posedge clk); #1;
                in_ready = 1'b1;
            end
            @(posedge clk); #1;
            in_ready = 1'b0;
            @(negedge clk);
            chk("in_valid_clear", in_valid, 1'b0);
            chk("in_delivered_once", deliv_q.size(), 1);
            chk("in_delivered_data", (deliv_q.size() > 0) ? {24'h0, deliv_q[0]} : 32'h1ff, {24'h0, data});
            wait_idle();
            chk("in_cs_len", (len1_q.size() > 0) ? len1_q.pop_front() : -1, LEN_LONG);
            chk("in_mosi_zero", (mor_q.size() > 0) ? mor_q.pop_front() : 1'bx, 1'b0);
        end
    endtask

    initial begin
        int k;
        logic [7:0] cbyte;
        logic [7:0] st;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {spi_cs_n, spi_sck, spi_mosi, busy, in_valid, out_ready}, {2'b11, 5'b00000});
        chk("rst_in_data", in_data, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_outputs", {spi_cs_n, spi_sck, busy, in_valid}, {2'b11, 3'b000});

        // reset during an active output transfer
        @(posedge clk); #1;
        out_data = 8'h5A; out_valid = 1'b1;
        @(posedge clk); #1;
        out_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_cs", spi_cs_n, 2'b10);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_cs", {spi_cs_n, spi_sck, busy}, {2'b11, 2'b00});
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("after_mid_rst", {spi_cs_n, spi_sck, busy, in_valid}, {2'b11, 3'b000});
        chk("after_mid_rst_in_data", in_data, 8'h00);
        clear_mon();

        // output bytes
        do_output(8'hA5);
        do_output(8'($urandom));
        do_output(8'($urandom));

        // input with data, then held delivery
        do_input(8'h01, 8'h3C, 0, 1'b1);
        do_input(8'($urandom_range(1, 255)), 8'($urandom), 20, 1'b0);

        // repeated empty polls: gap between them shows backoff (or its absence)
        clear_mon();
        @(posedge clk); #1;
        in_ready = 1'b1;
        k = 0;
        while (len1_q.size() < 2 && k < 600) begin
            @(negedge clk);
            k++;
        end
        in_ready = 1'b0;
        wait_idle();
        chk("poll_pair_count", len1_q.size(), 2);
        chk("poll_pair_len0", (len1_q.size() > 0) ? len1_q[0] : -1, LEN_SHORT);
        chk("poll_pair_len1", (len1_q.size() > 1) ? len1_q[1] : -1, LEN_SHORT);
        chk("poll_pair_gap", (gap_q.size() > 1) ? gap_q[1] : -1, POLL_HI);
        chk("poll_pair_no_delivery", deliv_q.size(), 0);

        // contention: both held, empty status -> strict alternation starting with output
        clear_mon();
        cbyte = 8'($urandom);
        @(posedge clk); #1;
        out_data = cbyte; out_valid = 1'b1; in_ready = 1'b1;
        k = 0;
        while (grant_q.size() < 6 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        out_valid = 1'b0; in_ready = 1'b0;
        wait_idle();
        chk("contend_grants", grant_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk("contend_order", (i < grant_q.size()) ? grant_q[i] : -1, i % 2);
        end
        for (int i = 1; i < 6; i++) begin
            chk("contend_gap", (i < gap_q.size()) ? gap_q[i] : -1, D + 1);
        end
        chk("contend_accepts", acc_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("contend_mosi_byte", (i < byte_q.size()) ? {24'h0, byte_q[i]} : 32'h1ff, {24'h0, cbyte});
        end
        clear_mon();

        // random mix
        for (int n = 0; n < 10; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                do_output(8'($urandom));
            end else begin
                st = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                do_input(st, 8'($urandom), 0, 1'b0);
            end
        end

        chk("cs_exclusive", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
